fix_field_serializer: RTL and testbench

- Transmit-side counterpart of the FIX field parser. Accepts one tag/value pair per handshake and serializes it to a byte stream in the form "tag=value<SOH>".
- Tracks a running FIX checksum per message. When a field is flagged last, it appends the trailer "10=ddd<SOH>".
- Sits between the order/message builder and the byte-wide line transmit path. Byte packing matches the receive side: byte 0 of each bus is the first character on the wire.

---
 rtl/fix_pkg.sv | 26 ++
 rtl/fix_cks_to_ascii.sv | 28 ++
 rtl/fix_field_serializer.sv | 230 +++++++++++++++++++++++
 tb/tb_fix_field_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants and state encoding for the FIX field serializer
// Purpose: ASCII constants, default bus widths and the serializer state enum.
// Ports: none (package).
package fix_pkg;

  localparam int TAG_BYTES = 4;
  localparam int VAL_BYTES = 32;

  localparam logic [7:0]  ASCII_EQ  = 8'h3D;
  localparam logic [7:0]  ASCII_SOH = 8'h01;
  localparam logic [7:0]  ASCII_0   = 8'h30;
  // "10": the first character on the wire is the upper byte.
  localparam logic [15:0] CKS_TAG   = "10";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_EQ,
    ST_VAL,
    ST_SOH,
    ST_CK_TAG,
    ST_CK_VAL,
    ST_CK_SOH
  } ser_state_e;

endpackage

// File: rtl/fix_cks_to_ascii.sv
// rtl/fix_cks_to_ascii.sv - 8-bit checksum to three ASCII decimal digits
// Purpose: combinational binary-to-decimal conversion for the "10=ddd" trailer.
// Ports:
//   cks_i  : 8-bit checksum value
//   hund_o : ASCII hundreds digit
//   tens_o : ASCII tens digit
//   ones_o : ASCII ones digit
module fix_cks_to_ascii (
  input  logic [7:0] cks_i,
  output logic [7:0] hund_o,
  output logic [7:0] tens_o,
  output logic [7:0] ones_o
);
  import fix_pkg::*;

  logic [7:0] hund;
  logic [7:0] tens;
  logic [7:0] ones;

  assign hund = cks_i / 8'd100;
  assign tens = (cks_i / 8'd10) % 8'd10;
  assign ones = cks_i % 8'd10;

  assign hund_o = ASCII_0 + hund;
  assign tens_o = ASCII_0 + tens;
  assign ones_o = ASCII_0 + ones;

endmodule

// File: rtl/fix_field_serializer.sv
// rtl/fix_field_serializer.sv - serializes tag/value pairs to "tag=value<SOH>" bytes
// Purpose: accepts one FIX field per handshake, emits it byte-wide, keeps a running
//          checksum and optionally appends "10=ddd<SOH>" after the last field.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   field_valid_i/ready_o  : field input handshake
//   tag_i, tag_len_i       : tag characters (byte 0 first) and count
//   value_i, value_len_i   : value characters (byte 0 first) and count
//   field_last_i           : field closes the message
//   data_o/valid_o/ready_i : byte output stream
//   sof_o, eom_o           : first byte / final SOH of a message
module fix_field_serializer #(
  parameter int TAG_BYTES    = fix_pkg::TAG_BYTES,
  parameter int VAL_BYTES    = fix_pkg::VAL_BYTES,
  parameter bit GEN_CHECKSUM = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   field_valid_i,
  output logic                   field_ready_o,
  input  logic [TAG_BYTES*8-1:0] tag_i,
  input  logic [2:0]             tag_len_i,
  input  logic [VAL_BYTES*8-1:0] value_i,
  input  logic [5:0]             value_len_i,
  input  logic                   field_last_i,
  output logic [7:0]             data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   sof_o,
  output logic                   eom_o
);
  import fix_pkg::*;

  // One byte index serves tag, value and trailer positions.
  localparam int IW  = $clog2(VAL_BYTES);
  localparam int TIW = $clog2(TAG_BYTES);

  ser_state_e             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TAG_BYTES*8-1:0] tag_q, tag_d;
  logic [VAL_BYTES*8-1:0] val_q, val_d;
  logic [IW-1:0]          tag_end_q, tag_end_d;
  logic [IW-1:0]          val_end_q, val_end_d;
  logic                   last_q, last_d;
  logic [7:0]             cks_q, cks_d;
  logic                   in_msg_q, in_msg_d;

  logic [7:0]    byte_out;
  logic          xfer;
  logic          sof;
  logic          eom;
  logic [IW-1:0] tag_end_sat;
  logic [IW-1:0] val_end_sat;
  logic [7:0]    tag_byte;
  logic [7:0]    val_byte;
  logic [7:0]    dig_hund;
  logic [7:0]    dig_tens;
  logic [7:0]    dig_ones;

  fix_cks_to_ascii u_cks_to_ascii (
    .cks_i  (cks_q),
    .hund_o (dig_hund),
    .tens_o (dig_tens),
    .ones_o (dig_ones)
  );

  assign tag_byte = tag_q[{idx_q[TIW-1:0], 3'b000} +: 8];
  assign val_byte = val_q[{idx_q, 3'b000} +: 8];

  assign field_ready_o = (state_q == ST_IDLE) && rst;
  assign data_valid_o  = (state_q != ST_IDLE);
  assign xfer          = data_valid_o && data_ready_i;
  assign sof           = (state_q == ST_TAG) && (idx_q == '0) && !in_msg_q;
  assign eom           = (state_q == ST_CK_SOH) ||
                         ((state_q == ST_SOH) && last_q && !GEN_CHECKSUM);

  assign data_o = byte_out;
  assign sof_o  = sof;
  assign eom_o  = eom;

  // Lengths are stored as the index of the final byte, saturated to 1..N characters.
  always_comb begin
    tag_end_sat = '0;
    val_end_sat = '0;
    if (tag_len_i == 3'd0) begin
      tag_end_sat = '0;
    end else if (int'(tag_len_i) > TAG_BYTES) begin
      tag_end_sat = IW'(TAG_BYTES - 1);
    end else begin
      tag_end_sat = IW'(tag_len_i - 3'd1);
    end
    if (value_len_i == 6'd0) begin
      val_end_sat = '0;
    end else if (int'(value_len_i) > VAL_BYTES) begin
      val_end_sat = IW'(VAL_BYTES - 1);
    end else begin
      val_end_sat = IW'(value_len_i - 6'd1);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    val_d     = val_q;
    tag_end_d = tag_end_q;
    val_end_d = val_end_q;
    last_d    = last_q;
    cks_d     = cks_q;
    in_msg_d  = in_msg_q;
    byte_out  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (field_valid_i && field_ready_o) begin
          tag_d     = tag_i;
          val_d     = value_i;
          tag_end_d = tag_end_sat;
          val_end_d = val_end_sat;
          last_d    = field_last_i;
          idx_d     = '0;
          state_d   = ST_TAG;
        end
      end
      ST_TAG: begin
        byte_out = tag_byte;
        if (xfer) begin
          if (idx_q == tag_end_q) begin
            idx_d   = '0;
            state_d = ST_EQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_EQ: begin
        byte_out = ASCII_EQ;
        if (xfer) state_d = ST_VAL;
      end
      ST_VAL: begin
        byte_out = val_byte;
        if (xfer) begin
          if (idx_q == val_end_q) begin
            idx_d   = '0;
            state_d = ST_SOH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_SOH: begin
        byte_out = ASCII_SOH;
        if (xfer) begin
          idx_d   = '0;
          state_d = (last_q && GEN_CHECKSUM) ? ST_CK_TAG : ST_IDLE;
        end
      end
      ST_CK_TAG: begin
        case (idx_q)
          IW'(0):  byte_out = CKS_TAG[15:8];
          IW'(1):  byte_out = CKS_TAG[7:0];
          default: byte_out = ASCII_EQ;
        endcase
        if (xfer) begin
          if (idx_q == IW'(2)) begin
            idx_d   = '0;
            state_d = ST_CK_VAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CK_VAL: begin
        case (idx_q)
          IW'(0):  byte_out = dig_hund;
          IW'(1):  byte_out = dig_tens;
          default: byte_out = dig_ones;
        endcase
        if (xfer) begin
          if (idx_q == IW'(2)) begin
            idx_d   = '0;
            state_d = ST_CK_SOH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CK_SOH: begin
        byte_out = ASCII_SOH;
        if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Only field bytes feed the checksum; trailer states leave it frozen for the digits.
    if (xfer && (state_q inside {ST_TAG, ST_EQ, ST_VAL, ST_SOH})) begin
      cks_d = cks_q + byte_out;
    end
    if (xfer && sof) in_msg_d = 1'b1;
    if (xfer && eom) begin
      in_msg_d = 1'b0;
      cks_d    = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      val_q     <= '0;
      tag_end_q <= '0;
      val_end_q <= '0;
      last_q    <= 1'b0;
      cks_q     <= 8'h00;
      in_msg_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      val_q     <= val_d;
      tag_end_q <= tag_end_d;
      val_end_q <= val_end_d;
      last_q    <= last_d;
      cks_q     <= cks_d;
      in_msg_q  <= in_msg_d;
    end
  end

endmodule

// File: tb/tb_fix_field_serializer.sv
// tb/tb_fix_field_serializer.sv - self-checking bench for fix_field_serializer
module tb_fix_field_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         field_valid_i;
  logic         field_ready_o;
  logic [31:0]  tag_i;
  logic [2:0]   tag_len_i;
  logic [255:0] value_i;
  logic [5:0]   value_len_i;
  logic         field_last_i;
  logic [7:0]   data_o;
  logic         data_valid_o;
  logic         data_ready_i;
  logic         sof_o;
  logic         eom_o;

  int total = 0;
  int bad   = 0;

  // Expected output bytes: {data, sof, eom}.
  logic [9:0] sb_q[$];
  logic [7:0] m_cks    = 8'h00;
  bit         m_in_msg = 1'b0;
  int         rdy_mode = 0;

  fix_field_serializer #(
    .TAG_BYTES    (4),
    .VAL_BYTES    (32),
    .GEN_CHECKSUM (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .field_valid_i (field_valid_i),
    .field_ready_o (field_ready_o),
    .tag_i         (tag_i),
    .tag_len_i     (tag_len_i),
    .value_i       (value_i),
    .value_len_i   (value_len_i),
    .field_last_i  (field_last_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .sof_o         (sof_o),
    .eom_o         (eom_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input string s);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < 32; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  task automatic push_b(input logic [7:0] b, input bit sof, input bit eom);
    sb_q.push_back({b, sof, eom});
  endtask

  // Ready pattern driver for the toggling and random phases.
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) data_ready_i = ~data_ready_i;
    else if (rdy_mode == 2) data_ready_i = 1'($urandom_range(0, 1));
  end

  // Scoreboard consumer: every transferred byte must match the head of the queue.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst === 1'b1 && data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_byte observed=%0h expected=none", data_o);
      end else begin
        e = sb_q.pop_front();
        check("byte_sof_eom", {22'd0, data_o, sof_o, eom_o}, {22'd0, e});
      end
    end
  end

  task automatic send_field(input logic [31:0] tag, input int tlen, input logic [255:0] val,
                            input int vlen, input bit last);
    int         t;
    int         v;
    logic [7:0] b;
    logic [7:0] ck;
    bit         got;
    t = (tlen == 0) ? 1 : ((tlen > 4) ? 4 : tlen);
    v = (vlen == 0) ? 1 : ((vlen > 32) ? 32 : vlen);
    for (int i = 0; i < t; i++) begin
      b = tag[8*i +: 8];
      push_b(b, (i == 0) && !m_in_msg, 1'b0);
      m_cks += b;
    end
    m_in_msg = 1'b1;
    push_b(8'h3D, 1'b0, 1'b0);
    m_cks += 8'h3D;
    for (int i = 0; i < v; i++) begin
      b = val[8*i +: 8];
      push_b(b, 1'b0, 1'b0);
      m_cks += b;
    end
    push_b(8'h01, 1'b0, 1'b0);
    m_cks += 8'h01;
    if (last) begin
      ck = m_cks;
      push_b(8'h31, 1'b0, 1'b0);
      push_b(8'h30, 1'b0, 1'b0);
      push_b(8'h3D, 1'b0, 1'b0);
      push_b(8'h30 + ck / 8'd100, 1'b0, 1'b0);
      push_b(8'h30 + (ck / 8'd10) % 8'd10, 1'b0, 1'b0);
      push_b(8'h30 + ck % 8'd10, 1'b0, 1'b0);
      push_b(8'h01, 1'b0, 1'b1);
      m_cks    = 8'h00;
      m_in_msg = 1'b0;
    end
    tag_i         = tag;
    tag_len_i     = tlen[2:0];
    value_i       = val;
    value_len_i   = vlen[5:0];
    field_last_i  = last;
    field_valid_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (field_ready_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    field_valid_i = 1'b0;
    check("field_capture", 32'(got), 32'd1);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && data_valid_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit found;
    rst           = 1'b0;
    field_valid_i = 1'b0;
    tag_i         = '0;
    tag_len_i     = '0;
    value_i       = '0;
    value_len_i   = '0;
    field_last_i  = 1'b0;
    data_ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(field_ready_o), 32'd0);
    check("reset_valid", 32'(data_valid_o), 32'd0);
    check("reset_data", 32'(data_o), 32'd0);
    check("reset_sof", 32'(sof_o), 32'd0);
    check("reset_eom", 32'(eom_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(field_ready_o), 32'd1);

    // Single last field: checksum 183.
    send_field(32'h38, 1, pack("A"), 1, 1'b1);
    drain("drain_cks183");

    // Non-last field; ready returns the cycle after the SOH transfer.
    send_field(32'h38, 1, pack("FIX.4.2"), 7, 1'b0);
    drain("drain_nonlast");
    check("ready_after_soh", 32'(field_ready_o), 32'd1);
    send_field(32'h3533, 2, pack("D"), 1, 1'b1);
    drain("drain_close1");

    // Checksum wrap: "58" = 32 x 'z' -> 235.
    send_field(32'h3835, 2, {32{8'h7A}}, 32, 1'b1);
    drain("drain_wrap");

    // Backpressure on the 'I' byte.
    send_field(32'h38, 1, pack("FIX.4.2"), 7, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (data_valid_o === 1'b1 && data_o === 8'h49) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("bp_found", 32'(found), 32'd1);
    data_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(data_valid_o), 32'd1);
      check("bp_hold_data", 32'(data_o), 32'h49);
      if (i == 2) begin
        @(posedge clk);
        #1;
        data_ready_i = 1'b1;
      end
    end
    send_field(32'h3235, 2, pack("ZZ"), 2, 1'b1);
    drain("drain_bp");

    // Saturation: tag_len 0 -> one char, value_len 40 -> 32 chars.
    send_field(32'h34333231, 0, pack("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345"), 40, 1'b1);
    drain("drain_sat");

    // Toggling and random ready.
    rdy_mode = 1;
    send_field(32'h3533, 2, pack("XYZ"), 3, 1'b0);
    send_field(32'h3834, 2, pack("hello"), 5, 1'b1);
    drain("drain_toggle");
    rdy_mode = 2;
    send_field(32'h39343833, 4, pack("0123456789"), 10, 1'b0);
    send_field(32'h31, 7, pack("q"), 0, 1'b1);
    drain("drain_random");
    rdy_mode = 0;
    data_ready_i = 1'b1;

    // Reset in the middle of the value.
    send_field(32'h3535, 2, pack("QRSTUVWXYZ"), 10, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (data_valid_o === 1'b1 && data_o === 8'h54) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("mid_value_found", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(data_valid_o), 32'd0);
    check("rst_mid_ready", 32'(field_ready_o), 32'd0);
    sb_q.delete();
    m_cks    = 8'h00;
    m_in_msg = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("ready_after_rst_mid", 32'(field_ready_o), 32'd1);
    send_field(32'h38, 1, pack("A"), 1, 1'b1);
    drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
